// File: rtl/sgdmac_read.sv
// sgdmac_read: scatter-gather DMA read engine. Issues AXI3 INCR bursts of at most 16 beats and pushes R data into the shared FIFO.
// Define SGDMAC_READ_RESP_CHK_EN to enable sticky R-channel checking (rresp/rid/rlast) on err_o.
module sgdmac_read #(
  parameter logic [3:0] ARID = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [3:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic        start_i,
  input  logic [47:0] cmd_i,
  output logic        done_o,
  output logic        err_o,
  input  logic        fifo_full_i,
  output logic        fifo_wren_o,
  output logic [31:0] fifo_wdata_o
);

  typedef enum logic [1:0] {S_IDLE, S_RREQ, S_RDATA} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [13:0] words_q, words_d;
  logic [3:0]  beats_q, beats_d;
  logic [3:0]  arlen;
  logic        r_hs;
  logic        unused_len_lsbs;

  assign arlen = (words_q >= 14'd16) ? 4'hF : (words_q[3:0] - 4'd1);
  assign r_hs  = (state_q == S_RDATA) && rvalid_i && !fifo_full_i;

  assign unused_len_lsbs = ^cmd_i[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      words_q <= 14'd0;
      beats_q <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      beats_q <= beats_d;
    end
  end

  // The beat counter, not rlast_i, decides when a burst is over.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    beats_d = beats_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = cmd_i[47:16];
          words_d = cmd_i[15:2];
          if (cmd_i[15:2] != 14'd0) state_d = S_RREQ;
        end
      end
      S_RREQ: begin
        if (arready_i) begin
          beats_d = arlen;
          addr_d  = addr_q + 32'd64;
          words_d = (words_q >= 14'd16) ? (words_q - 14'd16) : 14'd0;
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        if (r_hs) begin
          beats_d = beats_q - 4'd1;
          if (beats_q == 4'd0) state_d = (words_q != 14'd0) ? S_RREQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done_o    = 1'b0;
    arvalid_o = 1'b0;
    rready_o  = 1'b0;
    case (state_q)
      S_IDLE:  done_o    = 1'b1;
      S_RREQ:  arvalid_o = 1'b1;
      S_RDATA: rready_o  = !fifo_full_i;
      default: ;
    endcase
  end

  assign arid_o       = ARID;
  assign araddr_o     = addr_q;
  assign arlen_o      = arlen;
  assign arsize_o     = 3'b010;
  assign arburst_o    = 2'b01;
  assign fifo_wren_o  = rvalid_i & rready_o;
  assign fifo_wdata_o = rdata_i;

`ifdef SGDMAC_READ_RESP_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (r_hs && ((rresp_i != 2'b00) || (rid_i != ARID) || (rlast_i != (beats_q == 4'd0))))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_rchk;

  assign unused_rchk = ^{rid_i, rresp_i, rlast_i};
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_sgdmac_read.sv
// tb_sgdmac_read: table-driven bench for sgdmac_read with a cycle-level AXI read slave model.
// Honours SGDMAC_READ_RESP_CHK_EN when deciding the expected err_o.
module tb_sgdmac_read;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  arid_o;
  logic [31:0] araddr_o;
  logic [3:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [3:0]  rid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic        rvalid_i;
  logic        rready_o;
  logic        start_i;
  logic [47:0] cmd_i;
  logic        done_o;
  logic        err_o;
  logic        fifo_full_i;
  logic        fifo_wren_o;
  logic [31:0] fifo_wdata_o;

  int tests    = 0;
  int failures = 0;
  bit errSeen  = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    int          arDelay;
    bit          toggleFull;
    int          errBeat;
    bit          midStart;
    int          expAr;
    int          expPush;
    logic [3:0]  expLastArlen;
  } vec_t;

  vec_t vecs[9];

  sgdmac_read #(.ARID(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .start_i(start_i), .cmd_i(cmd_i), .done_o(done_o), .err_o(err_o),
    .fifo_full_i(fifo_full_i), .fifo_wren_o(fifo_wren_o), .fifo_wdata_o(fifo_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic arr, input logic rv, input logic [31:0] rd,
                               input logic rl, input logic [1:0] rr, input logic ff);
    arready_i   = arr;
    rvalid_i    = rv;
    rdata_i     = rd;
    rlast_i     = rl;
    rresp_i     = rr;
    fifo_full_i = ff;
  endtask

  // Slave model: one burst at a time, R beats offered every cycle once the AR is accepted.
  task automatic runCommand(input int vi, input logic [31:0] addr, input logic [15:0] len,
                            input int arDelay, input bit toggleFull, input int errBeat,
                            input bit midStart, output int nAr, output int nPush,
                            output logic [3:0] lastArlen);
    int          wordsLeft, reqLeft, beatsLeft, beatIdx, beatG, arWait, arIndex, cyc;
    bit          inData, fifoFull, arRdy, errExp;
    logic [31:0] burstAddr;
    logic [3:0]  expLen;
    string       tag;
    wordsLeft = int'(len[15:2]);
    reqLeft   = wordsLeft;
    beatsLeft = 0; beatIdx = 0; beatG = 0; arWait = 0; arIndex = 0;
    inData    = 1'b0;
    burstAddr = addr;
    nAr = 0; nPush = 0; lastArlen = 4'd0;

    @(negedge clk);
    start_i = 1'b1;
    cmd_i   = {addr, len};
    #1 checkOutput($sformatf("v%0d doneBeforeStart", vi), done_o, 1);

    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      start_i  = midStart && (cyc == 3);
      cmd_i    = start_i ? {32'h0000_9000, 16'd64} : {addr, len};
      fifoFull = toggleFull && (cyc % 2 == 1);
      arRdy    = !inData && (arWait >= arDelay);
      applyStimulus(arRdy, inData, (burstAddr + 32'(4 * beatIdx)) ^ PAT, beatsLeft == 1,
                    (beatG == errBeat) ? 2'b10 : 2'b00, fifoFull);
      #1;
`ifdef SGDMAC_READ_RESP_CHK_EN
      errExp = errSeen;
`else
      errExp = 1'b0;
`endif
      tag = $sformatf("v%0d c%0d", vi, cyc);
      checkOutput({tag, " done"},    done_o,      wordsLeft == 0);
      checkOutput({tag, " arvalid"}, arvalid_o,   !inData && reqLeft > 0);
      checkOutput({tag, " rready"},  rready_o,    inData && !fifoFull);
      checkOutput({tag, " wren"},    fifo_wren_o, inData && !fifoFull);
      checkOutput({tag, " err"},     err_o,       errExp);
      expLen = (reqLeft >= 16) ? 4'hF : 4'(reqLeft - 1);
      if (arvalid_o) begin
        checkOutput({tag, " araddr"}, araddr_o, addr + 32'(64 * arIndex));
        checkOutput({tag, " arlen"},  arlen_o,  expLen);
      end
      if (wordsLeft == 0 && !inData && cyc >= 3) break;

      if (fifo_wren_o) begin
        checkOutput({tag, " wdata"}, fifo_wdata_o, (addr + 32'(4 * nPush)) ^ PAT);
        nPush++;
      end
      if (rvalid_i && rready_o) begin
        beatsLeft--; beatIdx++; wordsLeft--;
        if (beatG == errBeat) errSeen = 1'b1;
        beatG++;
        if (beatsLeft <= 0) inData = 1'b0;
      end
      if (arvalid_o && arready_i) begin
        nAr++;
        lastArlen = arlen_o;
        burstAddr = addr + 32'(64 * arIndex);
        beatsLeft = (reqLeft >= 16) ? 16 : reqLeft;
        reqLeft   = reqLeft - beatsLeft;
        beatIdx   = 0;
        arIndex++;
        arWait    = 0;
        inData    = (beatsLeft > 0);
      end else if (!inData) begin
        arWait++;
      end
      cyc++;
    end
    checkOutput($sformatf("v%0d finished", vi), wordsLeft == 0 && !inData, 1);
  endtask

  initial begin
    int         nAr, nPush;
    logic [3:0] lastLen;

    vecs[0] = '{32'h0000_1000, 16'd64,  0, 1'b0, -1, 1'b0, 1, 16, 4'hF};
    vecs[1] = '{32'h0000_2000, 16'd200, 0, 1'b0, -1, 1'b0, 4, 50, 4'h1};
    vecs[2] = '{32'h0000_3000, 16'd0,   0, 1'b0, -1, 1'b0, 0, 0,  4'h0};
    vecs[3] = '{32'h0000_3000, 16'd3,   0, 1'b0, -1, 1'b0, 0, 0,  4'h0};
    vecs[4] = '{32'h0000_4000, 16'd32,  0, 1'b1, -1, 1'b0, 1, 8,  4'h7};
    vecs[5] = '{32'h0000_5000, 16'd128, 5, 1'b0, -1, 1'b1, 2, 32, 4'hF};
    vecs[6] = '{32'h0000_7000, 16'd4,   0, 1'b0, -1, 1'b0, 1, 1,  4'h0};
    vecs[7] = '{32'h0000_8000, 16'd68,  0, 1'b0, -1, 1'b0, 2, 17, 4'h0};
    vecs[8] = '{32'h0000_6000, 16'd64,  0, 1'b0, 3,  1'b0, 1, 16, 4'hF};

    rst_n   = 1'b0;
    start_i = 1'b0;
    cmd_i   = 48'd0;
    rid_i   = 4'd0;
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst done",    done_o,      1);
    checkOutput("rst arvalid", arvalid_o,   0);
    checkOutput("rst rready",  rready_o,    0);
    checkOutput("rst wren",    fifo_wren_o, 0);
    checkOutput("rst err",     err_o,       0);
    checkOutput("arid",        arid_o,      4'd0);
    checkOutput("arsize",      arsize_o,    3'b010);
    checkOutput("arburst",     arburst_o,   2'b01);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 2'b00, 1'b0);

    for (int i = 0; i < 9; i++) begin
      runCommand(i, vecs[i].addr, vecs[i].len, vecs[i].arDelay, vecs[i].toggleFull,
                 vecs[i].errBeat, vecs[i].midStart, nAr, nPush, lastLen);
      checkOutput($sformatf("v%0d numAr", i),     nAr,     vecs[i].expAr);
      checkOutput($sformatf("v%0d numPush", i),   nPush,   vecs[i].expPush);
      checkOutput($sformatf("v%0d lastArlen", i), lastLen, vecs[i].expLastArlen);
    end

    // Reset clears the sticky error.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    errSeen = 1'b0;
    checkOutput("errAfterReset", err_o, 0);

    // Reset in the middle of a burst discards it and returns to idle.
    @(negedge clk);
    start_i = 1'b1;
    cmd_i   = {32'h0000_A000, 16'd64};
    @(negedge clk);
    start_i = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 2'b00, 1'b0);
    #1 checkOutput("midRst arvalid", arvalid_o, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, 2'b00, 1'b0);
    #1 checkOutput("midRst rready", rready_o, 1);
    checkOutput("midRst wdata", fifo_wdata_o, 32'h1234_5678);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midRst done",    done_o,      1);
    checkOutput("midRst rready0", rready_o,    0);
    checkOutput("midRst wren",    fifo_wren_o, 0);
    checkOutput("midRst arvalid0", arvalid_o,  0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("postRst done", done_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
